spi_arbiter: RTL and testbench
==============================

SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 The block SHALL have one parameter: CLK_DIV, default 0, SPI half-period equal to CLK_DIV+1 clk_sys cycles (range 0..15).
REQ-002 clk_sys  in  1  system clock; the block SHALL have this one clock, with all logic on posedge.
REQ-003 nRESET  in  1  reset, synchronous and active-low.
REQ-004 req_a, req_b  in  1 each  level byte-transfer request; A is the CPU/divmmc port, B the secondary (loader) port.
REQ-005 cs_a, cs_b  in  1 each  requester wants the card selected (1 = select).
REQ-006 wdata_a, wdata_b  in  8 each  byte to transmit.
REQ-007 ack_a, ack_b  out  1 each  one-cycle transfer-done pulse.
REQ-008 rdata_a, rdata_b  out  8 each  last received byte for that port.
REQ-009 owner  out  2  00 none, 01 A, 10 B.
REQ-010 spi_ss  out  1; spi_clk  out  1; spi_do  out  1; spi_di  in  1  SD SPI bus, mode 0, MSB first.

Function
REQ-011 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-012 Lock: with owner=none, a rising cs_x SHALL make x owner next cycle; if cs_a and cs_b are both set, A SHALL win.
REQ-013 Owner SHALL release when its cs drops in IDLE; if it drops in SHIFT, release SHALL occur in DONE.
REQ-014 spi_ss SHALL be 0 exactly while owner != none.
REQ-015 Grant (IDLE only) SHALL go to the owner's pending request; non-owner requests SHALL stall without ack.
REQ-016 With owner=none, requests SHALL be granted with ss high (dummy init clocks), round-robin, and B SHALL win the first tie after reset.
REQ-017 On grant, the shift register SHALL load wdata_x and the FSM SHALL go to SHIFT the next cycle.
REQ-018 SHIFT: 8 bits; each bit SHALL be clk low CLK_DIV+1 cycles then high CLK_DIV+1 cycles; spi_di SHALL be sampled at the rising edge; spi_do SHALL change only while clk is low.
REQ-019 DONE (one cycle): rdata_x SHALL update and ack_x SHALL pulse; the FSM SHALL return to IDLE.
REQ-020 Latency: ack SHALL occur 2+16*(CLK_DIV+1) cycles after the IDLE cycle where req was sampled (CLK_DIV=0: 18 cycles).
REQ-021 req held high after ack SHALL start a new transfer, with back-to-back bytes having one IDLE cycle between them.
REQ-022 Idle bus: spi_clk SHALL be 0 and spi_do SHALL be 1.
REQ-023 wdata SHALL be sampled only at grant; later changes SHALL have no effect.

Reset
REQ-024 While nRESET=0, the block SHALL be: state IDLE, owner none, spi_ss 1, spi_clk 0, spi_do 1, ack_* 0, rdata_* 8'hFF, round-robin pointer A.
REQ-025 Reset mid-transfer SHALL abort next edge with no ack.

Configuration
REQ-026 When SPI_ARB_TIMEOUT_EN is defined, an owner holding cs with no request for 65536 consecutive cycles SHALL be force-released (owner none, ss 1), and re-lock SHALL need a fresh cs rising edge.
REQ-027 When SPI_ARB_TIMEOUT_EN is undefined, the lock SHALL be held indefinitely and no timeout counter SHALL exist.

Structure
REQ-028 Package spi_arb_pkg SHALL hold the FSM state enum, owner encodings (OWN_NONE/OWN_A/OWN_B) and timeout constant 16'hFFFF.
REQ-029 Sub-module spi_byte_engine SHALL own the shift register, divider and bit counter (start in, done/rx_byte out); the arbiter SHALL own lock, grant and FSM.

Verification
REQ-030 The bench SHALL cover: CLK_DIV=0, cs_a=1, req_a with wdata_a=8'hA5, spi_di looping spi_do -> spi_ss 0, 8 clocks, ack_a at cycle 18, rdata_a=8'hA5.
REQ-031 The bench SHALL cover: A owns, req_b and req_a asserted together -> only A served, ack_b never pulses until cs_a drops, then B locks and is served.
REQ-032 The bench SHALL cover: no cs, req_a and req_b held constantly -> grants alternate B,A,B,A with spi_ss constantly 1.
REQ-033 The bench SHALL cover: cs_a dropped mid-SHIFT -> transfer completes, ack_a pulses, owner none one cycle later.
REQ-034 The bench SHALL cover: nRESET pulsed at SHIFT bit 4 -> no ack, all outputs at reset values next cycle.
REQ-035 The bench SHALL cover: with SPI_ARB_TIMEOUT_EN, cs_b held with no req for 65536 cycles -> owner 00, spi_ss 1; without the macro -> still 10.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// rtl/spi_arb_pkg.sv - shared FSM states, owner encodings and timeout limit for spi_arbiter.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0]  OWN_NONE    = 2'b00;
  localparam logic [1:0]  OWN_A       = 2'b01;
  localparam logic [1:0]  OWN_B       = 2'b10;
  localparam logic [15:0] TIMEOUT_MAX = 16'hFFFF;

endpackage

// File: rtl/spi_byte_engine.sv
// rtl/spi_byte_engine.sv - SPI mode-0 byte shifter: divider, bit counter and shift register.
module spi_byte_engine #(
  parameter int CLK_DIV = 0
) (
  input  logic       clk_sys,
  input  logic       nRESET,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       spi_di,
  output logic       done,
  output logic [7:0] rx_byte,
  output logic       spi_clk,
  output logic       spi_do
);

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV);

  logic       active;
  logic       half;
  logic       di_bit;
  logic [3:0] div_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;

  // One register holds both directions: MISO is captured on the rising edge
  // and shifted in on the falling edge, when the next MOSI bit goes out.
  always_ff @(posedge clk_sys) begin
    if (!nRESET) begin
      active  <= 1'b0;
      half    <= 1'b0;
      di_bit  <= 1'b0;
      div_cnt <= 4'd0;
      bit_cnt <= 3'd0;
      shreg   <= 8'hFF;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        active  <= 1'b1;
        half    <= 1'b0;
        div_cnt <= 4'd0;
        bit_cnt <= 3'd0;
        shreg   <= tx_byte;
      end else if (active) begin
        if (div_cnt == DIV_LAST) begin
          div_cnt <= 4'd0;
          if (!half) begin
            half   <= 1'b1;
            di_bit <= spi_di;
          end else begin
            half    <= 1'b0;
            shreg   <= {shreg[6:0], di_bit};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              active <= 1'b0;
              done   <= 1'b1;
            end
          end
        end else begin
          div_cnt <= div_cnt + 4'd1;
        end
      end
    end
  end

  assign spi_clk = active & half;
  assign spi_do  = active ? shreg[7] : 1'b1;
  assign rx_byte = shreg;

endmodule

// File: rtl/spi_arbiter.sv
// rtl/spi_arbiter.sv - two-port SD SPI arbiter with card-select lock; SPI_ARB_TIMEOUT_EN adds an idle-lock timeout.
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int CLK_DIV = 0
) (
  input  logic       clk_sys,
  input  logic       nRESET,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       cs_a,
  input  logic       cs_b,
  input  logic [7:0] wdata_a,
  input  logic [7:0] wdata_b,
  output logic       ack_a,
  output logic       ack_b,
  output logic [7:0] rdata_a,
  output logic [7:0] rdata_b,
  output logic [1:0] owner,
  output logic       spi_ss,
  output logic       spi_clk,
  output logic       spi_do,
  input  logic       spi_di
);

  state_t     state;
  logic [1:0] rr_last;
  logic       cur_b;
  logic       cs_a_q, cs_b_q, arm_a, arm_b;
  logic       lock_a, lock_b, own_cs, grant, grant_b, eng_done;
  logic [7:0] rx_byte;

  // An edge on cs stays armed while another port owns the card, so the
  // waiting port locks as soon as the owner lets go.
  always_comb begin
    lock_a  = (owner == OWN_NONE) && cs_a && (arm_a || !cs_a_q);
    lock_b  = (owner == OWN_NONE) && cs_b && (arm_b || !cs_b_q) && !lock_a;
    own_cs  = (owner == OWN_A) ? cs_a : (owner == OWN_B) ? cs_b : 1'b0;
    grant   = 1'b0;
    grant_b = 1'b0;
    if (state == IDLE) begin
      if (owner == OWN_A) begin
        grant = cs_a && req_a;
      end else if (owner == OWN_B) begin
        grant   = cs_b && req_b;
        grant_b = 1'b1;
      end else if (!lock_a && !lock_b) begin
        grant   = req_a || req_b;
        grant_b = req_b && (!req_a || rr_last == OWN_A);
      end
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        tmo_idle, tmo_hit;

  always_comb begin
    tmo_idle = (state == IDLE) && (owner != OWN_NONE) && own_cs &&
               !((owner == OWN_A) ? req_a : req_b);
    tmo_hit  = tmo_idle && (tmo_cnt == TIMEOUT_MAX);
  end

  always_ff @(posedge clk_sys) begin
    if (!nRESET || !tmo_idle || tmo_hit) tmo_cnt <= 16'd0;
    else                                 tmo_cnt <= tmo_cnt + 16'd1;
  end
`endif

  always_ff @(posedge clk_sys) begin
    if (!nRESET) begin
      state   <= IDLE;
      owner   <= OWN_NONE;
      ack_a   <= 1'b0;
      ack_b   <= 1'b0;
      rdata_a <= 8'hFF;
      rdata_b <= 8'hFF;
      rr_last <= OWN_A;
      cur_b   <= 1'b0;
      cs_a_q  <= 1'b0;
      cs_b_q  <= 1'b0;
      arm_a   <= 1'b0;
      arm_b   <= 1'b0;
    end else begin
      cs_a_q <= cs_a;
      cs_b_q <= cs_b;
      arm_a  <= cs_a && (arm_a || !cs_a_q) && !lock_a;
      arm_b  <= cs_b && (arm_b || !cs_b_q) && !lock_b;
      ack_a  <= 1'b0;
      ack_b  <= 1'b0;
      if (lock_a)      owner <= OWN_A;
      else if (lock_b) owner <= OWN_B;
      else if ((state != SHIFT) && (owner != OWN_NONE) && !own_cs) owner <= OWN_NONE;
`ifdef SPI_ARB_TIMEOUT_EN
      else if (tmo_hit) owner <= OWN_NONE;
`endif
      case (state)
        IDLE: begin
          if (grant) begin
            state <= SHIFT;
            cur_b <= grant_b;
            if (owner == OWN_NONE) rr_last <= grant_b ? OWN_B : OWN_A;
          end
        end
        SHIFT: begin
          if (eng_done) begin
            state <= DONE;
            if (cur_b) begin
              ack_b   <= 1'b1;
              rdata_b <= rx_byte;
            end else begin
              ack_a   <= 1'b1;
              rdata_a <= rx_byte;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign spi_ss = (owner == OWN_NONE);

  spi_byte_engine #(.CLK_DIV(CLK_DIV)) u_engine (
    .clk_sys (clk_sys),
    .nRESET  (nRESET),
    .start   (grant),
    .tx_byte (grant_b ? wdata_b : wdata_a),
    .spi_di  (spi_di),
    .done    (eng_done),
    .rx_byte (rx_byte),
    .spi_clk (spi_clk),
    .spi_do  (spi_do)
  );

endmodule

// File: tb/tb_spi_arbiter.sv
// tb/tb_spi_arbiter.sv - directed self-checking bench for spi_arbiter (CLK_DIV=0, MISO looped to MOSI).
module tb_spi_arbiter;

  logic       clk_sys = 1'b0;
  logic       nRESET;
  logic       req_a, req_b, cs_a, cs_b;
  logic [7:0] wdata_a, wdata_b;
  logic       ack_a, ack_b;
  logic [7:0] rdata_a, rdata_b;
  logic [1:0] owner;
  logic       spi_ss, spi_clk, spi_do, spi_di;

  int total = 0;
  int bad   = 0;

  int lat, nclk, other;
  bit ss_low, ss_high;
  int cnt;

  always #5 clk_sys = ~clk_sys;

  assign spi_di = spi_do;

  spi_arbiter #(.CLK_DIV(0)) dut (
    .clk_sys (clk_sys),
    .nRESET  (nRESET),
    .req_a   (req_a),
    .req_b   (req_b),
    .cs_a    (cs_a),
    .cs_b    (cs_b),
    .wdata_a (wdata_a),
    .wdata_b (wdata_b),
    .ack_a   (ack_a),
    .ack_b   (ack_b),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b),
    .owner   (owner),
    .spi_ss  (spi_ss),
    .spi_clk (spi_clk),
    .spi_do  (spi_do),
    .spi_di  (spi_di)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Steps negedge by negedge until the chosen port acks; lat=0 means the budget ran out.
  task automatic run_to_ack(input bit port_b, input int budget, input bit mutate, input bit drop,
                            output int lat_o, output int nclk_o, output int other_o,
                            output bit ss_low_o, output bit ss_high_o);
    logic clk_prev;
    lat_o = 0; nclk_o = 0; other_o = 0; ss_low_o = 0; ss_high_o = 0;
    clk_prev = spi_clk;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk_sys);
      if (spi_clk && !clk_prev) nclk_o++;
      clk_prev = spi_clk;
      if (spi_ss) ss_high_o = 1; else ss_low_o = 1;
      if (port_b ? ack_a : ack_b) other_o++;
      if (mutate && n == 3) wdata_a = ~wdata_a;
      if (port_b ? ack_b : ack_a) begin
        lat_o = n;
        if (drop) begin
          if (port_b) req_b = 1'b0; else req_a = 1'b0;
        end
        break;
      end
    end
  endtask

  initial begin
    nRESET = 1'b0; req_a = 1'b0; req_b = 1'b0; cs_a = 1'b0; cs_b = 1'b0;
    wdata_a = 8'h00; wdata_b = 8'h00;
    repeat (3) @(negedge clk_sys);
    check("rst_owner", owner, 2'b00);
    check("rst_ss", spi_ss, 1'b1);
    check("rst_clk", spi_clk, 1'b0);
    check("rst_do", spi_do, 1'b1);
    check("rst_ack_a", ack_a, 1'b0);
    check("rst_ack_b", ack_b, 1'b0);
    check("rst_rdata_a", rdata_a, 8'hFF);
    check("rst_rdata_b", rdata_b, 8'hFF);
    nRESET = 1'b1;
    @(negedge clk_sys);

    // single locked transfer, wdata changed after grant
    cs_a = 1'b1;
    @(negedge clk_sys);
    check("lock_a_owner", owner, 2'b01);
    check("lock_a_ss", spi_ss, 1'b0);
    req_a = 1'b1; wdata_a = 8'hA5;
    run_to_ack(0, 40, 1, 1, lat, nclk, other, ss_low, ss_high);
    check("t1_latency", lat, 18);
    check("t1_sclk_count", nclk, 8);
    check("t1_rdata_a", rdata_a, 8'hA5);
    check("t1_ss_stayed_low", ss_high, 0);
    @(negedge clk_sys);
    check("t1_ack_pulse", ack_a, 1'b0);
    check("t1_idle_clk", spi_clk, 1'b0);
    check("t1_idle_do", spi_do, 1'b1);

    // A owns: B stalls until cs_a drops
    cs_b = 1'b1; req_a = 1'b1; req_b = 1'b1; wdata_a = 8'h3C; wdata_b = 8'hC3;
    run_to_ack(0, 40, 0, 1, lat, nclk, other, ss_low, ss_high);
    check("t2_a_latency", lat, 18);
    check("t2_no_ack_b", other, 0);
    check("t2_rdata_a", rdata_a, 8'h3C);
    cnt = 0;
    repeat (6) begin
      @(negedge clk_sys);
      if (ack_b) cnt++;
    end
    check("t2_b_stalled", cnt, 0);
    check("t2_owner_a", owner, 2'b01);
    cs_a = 1'b0;
    run_to_ack(1, 60, 0, 1, lat, nclk, other, ss_low, ss_high);
    check("t2_b_latency", lat, 20);
    check("t2_b_owner", owner, 2'b10);
    check("t2_b_ss", spi_ss, 1'b0);
    check("t2_rdata_b", rdata_b, 8'hC3);
    cs_b = 1'b0;
    @(negedge clk_sys);
    check("t2_release_owner", owner, 2'b00);
    check("t2_release_ss", spi_ss, 1'b1);

    // no owner: round-robin B,A,B,A with ss high
    wdata_a = 8'h11; wdata_b = 8'h22; req_a = 1'b1; req_b = 1'b1;
    for (int k = 0; k < 4; k++) begin
      run_to_ack((k % 2) == 0, 40, 0, k == 3, lat, nclk, other, ss_low, ss_high);
      if (k == 3) begin req_a = 1'b0; req_b = 1'b0; end
      check($sformatf("t3_lat_%0d", k), lat, (k == 0) ? 18 : 19);
      check($sformatf("t3_other_%0d", k), other, 0);
      check($sformatf("t3_ss_high_%0d", k), ss_low, 0);
      if ((k % 2) == 0) check($sformatf("t3_rdata_b_%0d", k), rdata_b, 8'h22);
      else              check($sformatf("t3_rdata_a_%0d", k), rdata_a, 8'h11);
    end
    @(negedge clk_sys);

    // cs_a dropped mid-shift: byte completes, release after DONE
    cs_a = 1'b1;
    @(negedge clk_sys);
    check("t4_owner_a", owner, 2'b01);
    req_a = 1'b1; wdata_a = 8'h5A;
    repeat (5) @(negedge clk_sys);
    cs_a = 1'b0;
    run_to_ack(0, 40, 0, 1, lat, nclk, other, ss_low, ss_high);
    check("t4_latency", lat, 13);
    check("t4_owner_at_ack", owner, 2'b01);
    check("t4_rdata_a", rdata_a, 8'h5A);
    @(negedge clk_sys);
    check("t4_owner_released", owner, 2'b00);
    check("t4_ss_released", spi_ss, 1'b1);

    // reset during bit 4
    cs_a = 1'b1;
    @(negedge clk_sys);
    req_a = 1'b1; wdata_a = 8'h96;
    repeat (9) @(negedge clk_sys);
    nRESET = 1'b0;
    @(negedge clk_sys);
    check("t5_owner", owner, 2'b00);
    check("t5_ss", spi_ss, 1'b1);
    check("t5_clk", spi_clk, 1'b0);
    check("t5_do", spi_do, 1'b1);
    check("t5_ack_a", ack_a, 1'b0);
    check("t5_rdata_a", rdata_a, 8'hFF);
    check("t5_rdata_b", rdata_b, 8'hFF);
    cs_a = 1'b0; req_a = 1'b0;
    cnt = 0;
    repeat (2) begin
      @(negedge clk_sys);
      if (ack_a) cnt++;
    end
    nRESET = 1'b1;
    repeat (25) begin
      @(negedge clk_sys);
      if (ack_a) cnt++;
    end
    check("t5_no_ack", cnt, 0);

    // lock held with no request for 65536 cycles
    cs_b = 1'b1;
    @(negedge clk_sys);
    check("t6_owner_b", owner, 2'b10);
    repeat (65530) @(negedge clk_sys);
    check("t6_owner_before_limit", owner, 2'b10);
    repeat (10) @(negedge clk_sys);
`ifdef SPI_ARB_TIMEOUT_EN
    check("t6_owner_timeout", owner, 2'b00);
    check("t6_ss_timeout", spi_ss, 1'b1);
    repeat (4) @(negedge clk_sys);
    check("t6_no_relock", owner, 2'b00);
`else
    check("t6_owner_held", owner, 2'b10);
    check("t6_ss_held", spi_ss, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
